decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Decode stage of the Y86-style processor. Sits directly downstream of the fetch stage.
- Accepts one fetched instruction per handshake as icode/ifun/rA/rB/valC. Reads source operands from an internal register file. Registers the result for the execute stage.
- Also owns the register file write port, which the write-back stage drives.
- Halts on HALT or on an illegal instruction.

Parameters:
- DATA_W, 16, register and valC width
- NREG, 15, architectural registers r0..r14 (4'hF = "no register")

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode can accept this cycle
- icode  in  4  instruction code
- ifun  in  4  function code
- rA  in  4  register field A
- rB  in  4  register field B
- valC  in  DATA_W  constant field
- wb_en  in  1  register file write enable
- wb_dst  in  4  write register; 4'hF means no write
- wb_val  in  DATA_W  write data
- out_valid  out  1  decoded instruction valid for execute
- out_ready  in  1  execute accepts
- out_icode  out  4  registered icode
- out_ifun  out  4  registered ifun
- out_dstE  out  4  destination register, or 4'hF
- out_valA  out  DATA_W  operand A
- out_valB  out  DATA_W  operand B
- out_valC  out  DATA_W  registered valC
- halted  out  1  sticky; HALT has been accepted
- illegal  out  1  sticky; illegal instruction has been accepted

Behaviour:
- Reset:
  - Outputs: out_valid=0; out_icode, out_ifun, out_valA, out_valB, out_valC = 0; out_dstE=4'hF; halted=0; illegal=0.
  - All registers r0..r14 = 0.
  - in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: discards any held instruction and register contents. Reset wins over a same-cycle transfer or write.
- in_ready = !halted && !illegal && (!out_valid || out_ready).
- Accept = in_valid && in_ready. Latency is 1 cycle: accepted instruction appears on out_* with out_valid=1 the next cycle.
- out_* hold stable while out_valid && !out_ready.
- out_valid clears after an out_ready cycle with no new accept.
- Simultaneous drain and accept keeps out_valid=1 with the new instruction.
- Decode table:
  - 0x0 HALT: no sources, dstE=F. Accepting it sets halted and forwards HALT with out_valid=1.
  - 0x1 IRMOV: requires rA=F and rB!=F. valA=0, valB=0, dstE=rB.
  - 0x2 OP (ifun 0 ADD, 1 SUB, 2 AND, 3 XOR): requires rA!=F and rB!=F. valA=R[rA], valB=R[rB], dstE=rB.
  - 0x3 RRMOV: requires rA!=F and rB!=F. valA=R[rA], valB=0, dstE=rB.
- Illegal = any other icode, OP with ifun>3, or a violated register-field rule. On accept: set illegal; out_valid stays 0 for that instruction (bubble).
- Once halted or illegal is set, in_ready stays 0 until reset. The instruction already in the output register still drains normally.
- Register file:
  - 2 combinational read ports, 1 synchronous write port.
  - Write when wb_en && wb_dst!=F. wb_dst=F with wb_en=1 is ignored.
  - Bypass: if a read address equals wb_dst in a cycle with a valid write, the read returns wb_val.
  - Read address F returns 0.
- Writes proceed regardless of handshake, halted or illegal state.

Decomposition:
- Package y86_pkg:
  - ICODE_HALT/IRMOV/OP/RRMOV
  - FUN_ADD/SUB/AND/XOR
  - REG_NONE=4'hF
  - INSTR_W=32 with field positions icode[31:28], ifun[27:24], rA[23:20], rB[19:16], valC[15:0]
  - DATA_W
- Sub-module reg_file: NREG x DATA_W array, synchronous reset to 0, two read ports with write bypass, one write port.
- decode_stage holds the decode logic, handshake and output register.

Test Plan:
- Reset, then IRMOV $8,%r5 (in=1_0_F_5_0008), out_ready=1 -> next cycle out_valid=1, out_icode=1, out_dstE=5, out_valC=0x0008, valA=valB=0.
- wb r5=8 and r4=3 on prior cycles, then SUB %r4,%r5 (2_1_4_5) -> out_ifun=1, out_valA=0x0003, out_valB=0x0008, out_dstE=5.
- wb_en=1, wb_dst=2, wb_val=0x1234 in the same cycle ADD %r1,%r2 is accepted -> out_valB=0x1234 (bypass); out_valA=R[1].
- out_ready=0 for 3 cycles with back-to-back instructions -> in_ready=0, out_* unchanged. Release -> second instruction appears next cycle, none lost or duplicated.
- HALT accepted -> halted=1, HALT emitted once, in_ready=0 and remains 0 with in_valid held. Assert reset -> halted=0, in_ready=1.
- icode=0x7, or IRMOV with rA=3 -> illegal=1, no out_valid pulse for it, in_ready=0. Mid-stream reset -> out_valid=0, registers read 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 decode definitions: opcode/function encodings, register sentinel,
// instruction field layout and the legality rule used by the decode stage.
package y86_pkg;

  localparam int DATA_W  = 16;
  localparam int INSTR_W = 32;

  localparam int ICODE_LSB = 28;
  localparam int IFUN_LSB  = 24;
  localparam int RA_LSB    = 20;
  localparam int RB_LSB    = 16;
  localparam int VALC_LSB  = 0;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [3:0] {
    ICODE_HALT  = 4'h0,
    ICODE_IRMOV = 4'h1,
    ICODE_OP    = 4'h2,
    ICODE_RRMOV = 4'h3
  } icode_t;

  typedef enum logic [3:0] {
    FUN_ADD = 4'h0,
    FUN_SUB = 4'h1,
    FUN_AND = 4'h2,
    FUN_XOR = 4'h3
  } fun_t;

  // Assembles a fetch word in the canonical field layout.
  function automatic logic [INSTR_W-1:0] pack_instr(input logic [3:0] icode, input logic [3:0] ifun,
                                                    input logic [3:0] ra, input logic [3:0] rb,
                                                    input logic [15:0] valc);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[ICODE_LSB +: 4] = icode;
    w[IFUN_LSB +: 4]  = ifun;
    w[RA_LSB +: 4]    = ra;
    w[RB_LSB +: 4]    = rb;
    w[VALC_LSB +: 16] = valc;
    return w;
  endfunction

  function automatic logic is_legal(input logic [3:0] icode, input logic [3:0] ifun,
                                    input logic [3:0] ra, input logic [3:0] rb);
    logic ok;
    ok = 1'b0;
    case (icode)
      ICODE_HALT:  ok = 1'b1;
      ICODE_IRMOV: ok = (ra == REG_NONE) && (rb != REG_NONE);
      ICODE_OP:    ok = (ifun <= FUN_XOR) && (ra != REG_NONE) && (rb != REG_NONE);
      ICODE_RRMOV: ok = (ra != REG_NONE) && (rb != REG_NONE);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass and one synchronous write port; address REG_NONE reads as zero.
module reg_file
  import y86_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        ra_addr,
  input  logic [3:0]        rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_hit;
  logic [3:0]        rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign wr_hit     = wr_en && (wr_addr != REG_NONE) && (int'(wr_addr) < NREG);
  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rb_addr;
  assign ra_data    = rd_data[0];
  assign rb_data    = rd_data[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = '0;
        if (rd_addr[gi] == REG_NONE || int'(rd_addr[gi]) >= NREG) rd_data[gi] = '0;
        else if (wr_hit && (wr_addr == rd_addr[gi])) rd_data[gi] = wr_data;
        else rd_data[gi] = regs[rd_addr[gi]];
      end
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// Y86 decode stage: checks instruction legality, reads operands, and holds the
// decoded result in a valid/ready output register until execute takes it.
module decode_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valC,
  input  logic              wb_en,
  input  logic [3:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [3:0]        out_dstE,
  output logic [DATA_W-1:0] out_valA,
  output logic [DATA_W-1:0] out_valB,
  output logic [DATA_W-1:0] out_valC,
  output logic              halted,
  output logic              illegal
);

  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] dec_valA, dec_valB;
  logic [3:0]        dec_dstE;
  logic              legal, accept;

  reg_file #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clock   (clock),
    .reset   (reset),
    .ra_addr (rA),
    .rb_addr (rB),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .wr_en   (wb_en),
    .wr_addr (wb_dst),
    .wr_data (wb_val)
  );

  assign in_ready = !halted && !illegal && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign legal    = is_legal(icode, ifun, rA, rB);

  always_comb begin
    dec_valA = '0;
    dec_valB = '0;
    dec_dstE = REG_NONE;
    case (icode)
      ICODE_IRMOV: dec_dstE = rB;
      ICODE_OP: begin
        dec_valA = rf_a;
        dec_valB = rf_b;
        dec_dstE = rB;
      end
      ICODE_RRMOV: begin
        dec_valA = rf_a;
        dec_dstE = rB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_icode <= '0;
      out_ifun  <= '0;
      out_dstE  <= REG_NONE;
      out_valA  <= '0;
      out_valB  <= '0;
      out_valC  <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && legal) begin
      out_valid <= 1'b1;
      out_icode <= icode;
      out_ifun  <= ifun;
      out_dstE  <= dec_dstE;
      out_valA  <= dec_valA;
      out_valB  <= dec_valB;
      out_valC  <= valC;
      if (icode == ICODE_HALT) halted <= 1'b1;
    end else if (accept) begin
      // Illegal instruction becomes a bubble; any prior entry drained this cycle.
      out_valid <= 1'b0;
      illegal   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised self-checking bench for decode_stage against a cycle-level model
// built from the architectural rules (register array plus output slot state).
module tb_decode_stage;
  import y86_pkg::*;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, wb_en, out_valid, out_ready, halted, illegal;
  logic [3:0]  icode, ifun, rA, rB, wb_dst, out_icode, out_ifun, out_dstE;
  logic [15:0] valC, wb_val, out_valA, out_valB, out_valC;

  int n_vec = 0;
  int n_bad = 0;

  // Model state.
  logic [15:0] m_regs [15];
  logic        m_valid, m_halt, m_ill;
  logic [3:0]  m_icode, m_ifun, m_dst;
  logic [15:0] m_va, m_vb, m_vc;

  always #5 clock = ~clock;

  decode_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .wb_en(wb_en), .wb_dst(wb_dst), .wb_val(wb_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_ifun(out_ifun), .out_dstE(out_dstE), .out_valA(out_valA),
    .out_valB(out_valB), .out_valC(out_valC), .halted(halted), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (a == 4'hF) return 16'h0;
    if (wb_en && wb_dst != 4'hF && wb_dst == a) return wb_val;
    return m_regs[a];
  endfunction

  function automatic logic m_legal(input logic [3:0] c, input logic [3:0] f,
                                   input logic [3:0] a, input logic [3:0] b);
    if (c == 4'h0) return 1'b1;
    if (c == 4'h1) return a == 4'hF && b != 4'hF;
    if (c == 4'h2) return f < 4 && a != 4'hF && b != 4'hF;
    if (c == 4'h3) return a != 4'hF && b != 4'hF;
    return 1'b0;
  endfunction

  // Applies the currently driven inputs for one clock and checks the result.
  task automatic step();
    logic        rdy, acc;
    logic [15:0] nva, nvb;
    logic        nwr;
    rdy = !m_halt && !m_ill && (!m_valid || out_ready);
    acc = in_valid && rdy;
    nva = (icode == 4'h2 || icode == 4'h3) ? m_read(rA) : 16'h0;
    nvb = (icode == 4'h2) ? m_read(rB) : 16'h0;
    nwr = wb_en && wb_dst != 4'hF;
    @(posedge clock);
    if (reset) begin
      m_valid = 0; m_halt = 0; m_ill = 0;
      m_icode = 0; m_ifun = 0; m_dst = 4'hF; m_va = 0; m_vb = 0; m_vc = 0;
      for (int i = 0; i < 15; i++) m_regs[i] = 16'h0;
    end else begin
      if (acc && m_legal(icode, ifun, rA, rB)) begin
        m_valid = 1; m_icode = icode; m_ifun = ifun; m_vc = valC;
        m_dst = (icode == 4'h0) ? 4'hF : rB;
        m_va = nva; m_vb = nvb;
        if (icode == 4'h0) m_halt = 1;
      end else if (acc) begin
        m_valid = 0; m_ill = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (nwr) m_regs[wb_dst] = wb_val;
    end
    @(negedge clock);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("halted", {31'b0, halted}, {31'b0, m_halt});
    check("illegal", {31'b0, illegal}, {31'b0, m_ill});
    check("in_ready", {31'b0, in_ready}, {31'b0, !m_halt && !m_ill && (!m_valid || out_ready)});
    if (m_valid || reset) begin
      check("out_icode", {28'b0, out_icode}, {28'b0, m_icode});
      check("out_ifun", {28'b0, out_ifun}, {28'b0, m_ifun});
      check("out_dstE", {28'b0, out_dstE}, {28'b0, m_dst});
      check("out_valA", {16'b0, out_valA}, {16'b0, m_va});
      check("out_valB", {16'b0, out_valB}, {16'b0, m_vb});
      check("out_valC", {16'b0, out_valC}, {16'b0, m_vc});
    end
    $display("cyc rst=%0b acc=%0b in=%h ov=%0b or=%0b ic=%h dst=%h A=%h B=%h C=%h h=%0b i=%0b",
             reset, acc, pack_instr(icode, ifun, rA, rB, valC), out_valid, out_ready,
             out_icode, out_dstE, out_valA, out_valB, out_valC, halted, illegal);
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [31:0] instr,
                       input logic we, input logic [3:0] wd, input logic [15:0] wv,
                       input logic ordy);
    reset = rst; in_valid = iv;
    icode = instr[31:28]; ifun = instr[27:24]; rA = instr[23:20]; rB = instr[19:16];
    valC = instr[15:0];
    wb_en = we; wb_dst = wd; wb_val = wv; out_ready = ordy;
    step();
  endtask

  initial begin
    drive(1, 0, 32'h0, 0, 4'hF, 0, 1);
    drive(1, 0, 32'h0, 0, 4'hF, 0, 1);
    // IRMOV $8,%r5
    drive(0, 1, 32'h10F5_0008, 0, 4'hF, 0, 1);
    drive(0, 0, 32'h0, 1, 4'h5, 16'h0008, 1);
    drive(0, 0, 32'h0, 1, 4'h4, 16'h0003, 1);
    // SUB %r4,%r5
    drive(0, 1, 32'h2145_0000, 0, 4'hF, 0, 1);
    // ADD %r1,%r2 with same-cycle write of r2 (bypass)
    drive(0, 1, 32'h2012_0000, 1, 4'h2, 16'h1234, 1);
    // Back-to-back under a 3-cycle stall, then release
    drive(0, 1, 32'h3045_0000, 0, 4'hF, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h10F7_00AB, 0, 4'hF, 0, 0);
    drive(0, 1, 32'h10F7_00AB, 0, 4'hF, 0, 1);
    drive(0, 0, 32'h0, 0, 4'hF, 0, 1);
    // HALT, held in_valid, then reset
    drive(0, 1, 32'h0000_0000, 0, 4'hF, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h10F3_0001, 0, 4'hF, 0, 1);
    drive(1, 0, 32'h0, 0, 4'hF, 0, 1);
    // Illegal icode 7, then IRMOV with rA=3
    drive(0, 1, 32'h7012_0000, 0, 4'hF, 0, 1);
    drive(0, 1, 32'h10F3_0001, 0, 4'hF, 0, 1);
    drive(1, 0, 32'h0, 0, 4'hF, 0, 1);
    drive(0, 1, 32'h1035_0001, 0, 4'hF, 0, 1);
    drive(0, 0, 32'h0, 0, 4'hF, 0, 1);
    // Mid-stream reset, then registers must read zero
    drive(1, 0, 32'h0, 0, 4'hF, 0, 1);
    drive(0, 1, 32'h2045_0000, 0, 4'hF, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] c, f, a, b;
      int r;
      r = $urandom_range(0, 99);
      c = (r < 3) ? 4'h0 : (r < 33) ? 4'h1 : (r < 68) ? 4'h2 : (r < 96) ? 4'h3
                                                               : 4'($urandom_range(4, 15));
      f = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      a = ($urandom_range(0, 19) == 0) ? 4'($urandom) : ((c == 4'h1) ? 4'hF : 4'($urandom_range(0, 14)));
      b = ($urandom_range(0, 29) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      reset = ((m_halt || m_ill) && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      icode = c; ifun = f; rA = a; rB = b; valC = 16'($urandom);
      wb_en = $urandom_range(0, 1) == 1;
      wb_dst = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      wb_val = 16'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
